// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer with req/ack memory port.
// Optional misaligned-branch trap and halt: define PC_MISALIGN_TRAP_EN.
module pc_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4_out,
  output logic            trap
);

`ifdef PC_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    IDLE, FETCH, VALID, HALT
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE, FETCH, VALID
  } state_e;
`endif

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] pc_plus4;
  logic            retire;

  assign pc_plus4     = pc_q + {{(XLEN-3){1'b0}}, 3'd4};
  assign imem_req     = (state_q == FETCH);
  assign imem_addr    = pc_q;
  assign instr        = instr_q;
  assign instr_valid  = (state_q == VALID);
  assign pc_out       = pc_q;
  assign pc_plus4_out = pc_plus4;
  assign retire       = instr_valid & instr_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    trap_d  = 1'b0;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = VALID;
        end
      end
      VALID: begin
        if (retire) begin
`ifdef PC_MISALIGN_TRAP_EN
          if (branch_taken && (branch_target[1:0] != 2'b00)) begin
            trap_d  = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = branch_taken ? branch_target : pc_plus4;
            state_d = FETCH;
          end
`else
          // Without the trap, misaligned targets are silently aligned down
          pc_d    = branch_taken ?
                    {branch_target[XLEN-1:2], 2'b00} : pc_plus4;
          state_d = FETCH;
`endif
        end
      end
`ifdef PC_MISALIGN_TRAP_EN
      HALT:    state_d = HALT;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      trap_q  <= trap_d;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign trap = trap_q;
`else
  assign trap = 1'b0;
  logic unused_trap;
  assign unused_trap = trap_q;
`endif

endmodule
